// File: rtl/snp_ctrl_pkg.sv
// Shared definitions for the phase-snapshot capture controller.
//   state_t     : capture FSM states
//   CTRL_*      : bit positions inside the 32-bit control word
//   ST_*        : bit positions inside the 32-bit status word
package snp_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int unsigned CTRL_ARM     = 0;
  localparam int unsigned CTRL_TRIG_EN = 1;
  localparam int unsigned CTRL_LEN_LSB = 16;
  localparam int unsigned CTRL_LEN_MSB = 31;

  localparam int unsigned ST_DONE  = 31;
  localparam int unsigned ST_BUSY  = 30;
  localparam int unsigned ST_ARMED = 29;

endpackage

// File: rtl/snp_rise_detect.sv
// Rising-edge detector with a registered history bit.
//   clk  : clock
//   rst  : synchronous active-high reset; history bit resets to INIT
//   d    : level input
//   rise : d & ~previous d (combinational from the current d)
// With INIT=1 a level held high through reset is not reported as an edge.
module snp_rise_detect #(
  parameter logic INIT = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev <= INIT;
    end else begin
      prev <= d;
    end
  end

  assign rise = d & ~prev;

endmodule

// File: rtl/snp_phs_ss_capture_ctrl.sv
// Phase-snapshot capture controller.
// Decodes the software control word, waits for an optional external trigger,
// streams qualified phase samples into the snapshot BRAM and reports status.
//   user_clk    : sole clock
//   user_rst    : synchronous active-high reset
//   ctrl_word   : [0] arm (rising edge starts), [1] ext_trig_en, [31:16] length
//   din         : phase sample
//   din_valid   : sample qualifier
//   ext_trig    : external trigger level, honoured only while ARMED
//   bram_we     : BRAM write enable (one cycle per sample)
//   bram_addr   : BRAM write address
//   bram_din    : BRAM write data
//   status_word : [31] done, [30] busy, [29] armed, [ADDR_W:0] samples written
module snp_phs_ss_capture_ctrl
  import snp_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic              user_clk,
  input  logic              user_rst,
  input  logic [31:0]       ctrl_word,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  input  logic              ext_trig,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_din,
  output logic [31:0]       status_word
);

  localparam int unsigned     DEPTH   = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W + 1)'(1);

  state_t            state, state_nxt;
  logic [ADDR_W:0]   count;
  logic [ADDR_W:0]   count_inc;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   len_clamped;
  logic [15:0]       len_field;
  logic              arm_rise;
  logic              start;
  logic              accept;
  logic [31:0]       status_nxt;
  logic              ctrl_unused;

  assign ctrl_unused = ^ctrl_word[CTRL_LEN_LSB-1:CTRL_TRIG_EN+1];

  snp_rise_detect #(
    .INIT(1'b1)
  ) u_arm_rise (
    .clk  (user_clk),
    .rst  (user_rst),
    .d    (ctrl_word[CTRL_ARM]),
    .rise (arm_rise)
  );

  // Zero or oversize lengths mean "fill the whole BRAM".
  always_comb begin
    len_field = ctrl_word[CTRL_LEN_MSB:CTRL_LEN_LSB];
    if (len_field == 16'd0 || 32'(len_field) > DEPTH) begin
      len_clamped = DEPTH_C;
    end else begin
      len_clamped = (ADDR_W + 1)'(len_field);
    end
  end

  assign count_inc = count + ONE_C;

  // The trigger cycle itself may carry sample 0, so ARMED can accept and
  // (for len 1) finish in one step.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (arm_rise) begin
          start     = 1'b1;
          state_nxt = ctrl_word[CTRL_TRIG_EN] ? ARMED : CAPTURE;
        end
      end
      ARMED: begin
        if (ext_trig) begin
          state_nxt = CAPTURE;
          if (din_valid) begin
            accept = 1'b1;
            if (count_inc == len_q) state_nxt = DONE;
          end
        end
      end
      CAPTURE: begin
        if (din_valid) begin
          accept = 1'b1;
          if (count_inc == len_q) state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    status_nxt              = '0;
    status_nxt[ST_DONE]     = (state == DONE);
    status_nxt[ST_BUSY]     = (state == ARMED) || (state == CAPTURE);
    status_nxt[ST_ARMED]    = (state == ARMED);
    status_nxt[ADDR_W:0]    = count;
  end

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      state       <= IDLE;
      count       <= '0;
      len_q       <= DEPTH_C;
      bram_we     <= 1'b0;
      bram_addr   <= '0;
      bram_din    <= '0;
      status_word <= '0;
    end else begin
      state       <= state_nxt;
      bram_we     <= accept;
      status_word <= status_nxt;
      if (start) begin
        count <= '0;
        len_q <= len_clamped;
      end else if (accept) begin
        count <= count_inc;
      end
      if (accept) begin
        bram_addr <= count[ADDR_W-1:0];
        bram_din  <= din;
      end
    end
  end

endmodule

// File: tb/tb_snp_phs_ss_capture_ctrl.sv
module tb_snp_phs_ss_capture_ctrl;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 10;

  logic              user_clk;
  logic              user_rst;
  logic [31:0]       ctrl_word;
  logic [DATA_W-1:0] din;
  logic              din_valid;
  logic              ext_trig;
  logic              bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_din;
  logic [31:0]       status_word;

  int checks = 0;
  int errors = 0;

  logic [ADDR_W+DATA_W-1:0] sb_q[$];

  snp_phs_ss_capture_ctrl #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) dut (
    .user_clk    (user_clk),
    .user_rst    (user_rst),
    .ctrl_word   (ctrl_word),
    .din         (din),
    .din_valid   (din_valid),
    .ext_trig    (ext_trig),
    .bram_we     (bram_we),
    .bram_addr   (bram_addr),
    .bram_din    (bram_din),
    .status_word (status_word)
  );

  initial user_clk = 1'b0;
  always #5 user_clk = ~user_clk;

  // Scoreboard: every write seen at the negedge must match the oldest expected entry.
  task automatic sb_monitor();
    logic [ADDR_W+DATA_W-1:0] exp_e;
    if (bram_we !== 1'b0) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write we=%b addr=%0d data=%h required no write",
                 bram_we, bram_addr, bram_din);
      end else begin
        exp_e = sb_q.pop_front();
        if ({bram_addr, bram_din} !== exp_e)
          begin
            errors++;
            $display("FAIL write_data got addr=%0d data=%h required addr=%0d data=%h",
                     bram_addr, bram_din, exp_e[ADDR_W+DATA_W-1:DATA_W], exp_e[DATA_W-1:0]);
          end
      end
    end
  endtask

  task automatic tick();
    @(negedge user_clk);
    sb_monitor();
    @(posedge user_clk);
    #1;
  endtask

  task automatic arm_start(input logic [31:0] ctrl);
    ctrl_word = ctrl & 32'hFFFF_FFFE;
    tick();
    ctrl_word = ctrl;
    tick();
  endtask

  task automatic drain_and_status(input string name, input logic [31:0] exp_status);
    din_valid = 1'b0;
    tick();
    checks++;
    if (status_word !== exp_status) begin
      errors++;
      $display("FAIL %s status got %h required %h", name, status_word, exp_status);
    end
    tick();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL %s sb_drain got %0d pending writes required 0", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_reset();
    user_rst  = 1'b1;
    ctrl_word = 32'h0004_0001;
    din       = '0;
    din_valid = 1'b0;
    ext_trig  = 1'b0;
    @(posedge user_clk);
    #1;
    tick();
    checks++;
    if (bram_we !== 1'b0 || bram_addr !== '0 || bram_din !== '0 || status_word !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs got we=%b addr=%0d din=%h status=%h required all 0",
               bram_we, bram_addr, bram_din, status_word);
    end
    user_rst  = 1'b0;
    din_valid = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (status_word !== 32'h0) begin
      errors++;
      $display("FAIL reset_arm_held status got %h required 00000000", status_word);
    end
    din_valid = 1'b0;
    ctrl_word = 32'h0;
    tick();
  endtask

  task automatic test_immediate();
    arm_start(32'h0004_0001);
    for (int i = 0; i < 4; i++) begin
      din_valid = 1'b1;
      din = 32'hA0 + 32'(i);
      sb_q.push_back({ADDR_W'(i), din});
      tick();
    end
    drain_and_status("immediate", 32'h8000_0004);
  endtask

  task automatic test_ext_trigger();
    arm_start(32'h0003_0003);
    for (int i = 0; i < 10; i++) begin
      din_valid = 1'b1;
      din = 32'hDEAD_0000 + 32'(i);
      tick();
      checks++;
      if (status_word !== 32'h6000_0000) begin
        errors++;
        $display("FAIL ext_trig_armed cycle %0d status got %h required 60000000", i, status_word);
      end
    end
    for (int i = 0; i < 3; i++) begin
      ext_trig  = (i == 0);
      din_valid = 1'b1;
      din = 32'hB0 + 32'(i);
      sb_q.push_back({ADDR_W'(i), din});
      tick();
    end
    ext_trig = 1'b0;
    drain_and_status("ext_trigger", 32'h8000_0003);
  endtask

  task automatic test_full_depth(input logic [31:0] ctrl, input string name);
    arm_start(ctrl);
    for (int i = 0; i < 1030; i++) begin
      din_valid = 1'b1;
      din = 32'h5500_0000 + 32'(i);
      if (i < 1024) sb_q.push_back({ADDR_W'(i), din});
      tick();
    end
    drain_and_status(name, 32'h8000_0400);
  endtask

  task automatic test_rearm();
    arm_start(32'h0008_0001);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) ctrl_word = 32'h0008_0000;
      if (i == 4) ctrl_word = 32'h0002_0001;
      din_valid = 1'b1;
      din = 32'hC0 + 32'(i);
      sb_q.push_back({ADDR_W'(i), din});
      tick();
    end
    drain_and_status("rearm_ignored", 32'h8000_0008);
    arm_start(32'h0002_0001);
    din_valid = 1'b0;
    tick();
    checks++;
    if (status_word !== 32'h4000_0000) begin
      errors++;
      $display("FAIL rearm_restart status got %h required 40000000", status_word);
    end
    for (int i = 0; i < 2; i++) begin
      din_valid = 1'b1;
      din = 32'hD0 + 32'(i);
      sb_q.push_back({ADDR_W'(i), din});
      tick();
    end
    drain_and_status("rearm_second", 32'h8000_0002);
  endtask

  task automatic test_reset_mid();
    arm_start(32'h0008_0001);
    for (int i = 0; i < 2; i++) begin
      din_valid = 1'b1;
      din = 32'hE0 + 32'(i);
      sb_q.push_back({ADDR_W'(i), din});
      tick();
    end
    user_rst  = 1'b1;
    din_valid = 1'b1;
    din       = 32'hBAD0_0000;
    tick();
    user_rst = 1'b0;
    checks++;
    if (bram_we !== 1'b0 || status_word !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid got we=%b status=%h required we=0 status=00000000",
               bram_we, status_word);
    end
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (status_word !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_no_restart status got %h required 00000000", status_word);
    end
    arm_start(32'h0003_0001);
    for (int i = 0; i < 3; i++) begin
      din_valid = 1'b1;
      din = 32'hF0 + 32'(i);
      sb_q.push_back({ADDR_W'(i), din});
      tick();
    end
    drain_and_status("reset_mid_restart", 32'h8000_0003);
  endtask

  task automatic test_gaps();
    int n;
    n = 0;
    arm_start(32'h0005_0001);
    for (int i = 0; i < 10; i++) begin
      din_valid = (i % 2 == 0);
      din = 32'h7700 + 32'(i);
      if (din_valid) begin
        sb_q.push_back({ADDR_W'(n), din});
        n++;
      end
      tick();
    end
    drain_and_status("gaps", 32'h8000_0005);
  endtask

  initial begin
    test_reset();
    test_immediate();
    test_ext_trigger();
    test_full_depth(32'h0000_0001, "len_zero");
    test_full_depth(32'hFFFF_0001, "len_ffff");
    test_rearm();
    test_reset_mid();
    test_gaps();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
